if_fetch_buf: RTL and testbench

- Parametrised instruction-fetch stage and successor to the single-cycle fetch slice.
- Holds the program counter and issues requests on a req/gnt instruction-memory port, which tolerates variable latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode on a valid/ready handshake.
- Supports branch redirect with flush of buffered and in-flight fetches.

---
 rtl/if_fetch_buf.sv | 113 +++++++++++
 tb/tb_if_fetch_buf.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
// Instruction fetch: PC + credit-limited req/gnt issue, in-order response tagging, DEPTH-entry decode FIFO.
// Latency: response visible at out_* the cycle after im_rvalid; redirect flushes buffered and in-flight fetches.
module if_fetch_buf #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter int PC_STEP = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               im_req,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic               im_gnt,
    input  logic               im_rvalid,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_inc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   aq_wr;
    logic [PTR_W-1:0]   aq_rd;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [ADDR_W-1:0]  aq_mem    [DEPTH];

    logic               issue;
    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W:0]     credit_sum;

    // Every slot that is buffered or still owed by memory consumes one credit.
    assign credit_sum = {1'b0, inflight} + {1'b0, count};
    assign im_req     = !rst && !redirect && (credit_sum < (CNT_W+1)'(DEPTH));
    assign im_addr    = pc;
    assign issue      = im_req && im_gnt;
    assign fifo_push  = im_rvalid && !redirect && (drop == '0);
    assign fifo_pop   = (count != '0) && out_ready;

    assign out_valid  = (count != '0);
    assign out_instr  = rst ? '0 : instr_mem[rd_ptr];
    assign out_pc     = rst ? '0 : pc_mem[rd_ptr];
    assign out_pc_inc = rst ? '0 : pc_mem[rd_ptr] + ADDR_W'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            aq_wr    <= '0;
            aq_rd    <= '0;
        end else begin
            if (redirect)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + ADDR_W'(PC_STEP);

            inflight <= inflight + CNT_W'(issue) - CNT_W'(im_rvalid);
            if (issue)
                aq_wr <= aq_wr + 1'b1;
            if (im_rvalid)
                aq_rd <= aq_rd + 1'b1;

            // Everything still owed by memory is stale once we redirect,
            // except a response consumed in this very cycle.
            if (redirect)
                drop <= inflight - CNT_W'(im_rvalid);
            else if (im_rvalid && (drop != '0))
                drop <= drop - 1'b1;

            if (redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (fifo_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (fifo_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            aq_mem[aq_wr] <= pc;
        if (fifo_push) begin
            instr_mem[wr_ptr] <= im_rdata;
            pc_mem[wr_ptr]    <= aq_mem[aq_rd];
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !fifo_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_buf.sv
// Randomized bench for if_fetch_buf against a queue-level model of the fetch buffer.
module tb_if_fetch_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        im_gnt = 1'b0;
    logic        im_rvalid = 1'b0;
    logic [15:0] im_rdata = '0;
    logic        out_ready = 1'b0;
    logic        im_req, out_valid;
    logic [15:0] im_addr, out_instr, out_pc, out_pc_inc;
    logic        w_im_req, w_out_valid;
    logic [15:0] w_im_addr, w_out_instr, w_out_pc, w_out_pc_inc;

    if_fetch_buf dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_inc(out_pc_inc)
    );

    if_fetch_buf #(.RESET_PC(16'hFFF8)) u_wrap (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_req(w_im_req), .im_addr(w_im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .out_pc_inc(w_out_pc_inc)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;

    // stimulus knobs
    int gnt_pct, rv_pct, ready_pct, redir_pct, lat_extra, resp_lim;
    bit redir_once;
    logic [15:0] redir_addr;

    // memory environment
    logic [15:0] mem_addr[$];
    int          mem_due[$];
    int          resp_cnt, grants, first_g, first_v;
    logic [15:0] gaddr[$];

    // reference model
    logic [15:0] mpc;
    logic [15:0] expq_pc[$];
    logic [15:0] expq_in[$];
    logic [15:0] pend_addr[$];
    bit          pend_stale[$];
    logic [15:0] deliv[$];
    int          ndrop;
    bit          coinc, saw_fffc;
    logic [15:0] inc_fffc;

    function automatic logic [15:0] imem(input logic [15:0] a);
        return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic knobs(input int g, input int rv, input int rd, input int rr, input int lx);
        gnt_pct = g; rv_pct = rv; ready_pct = rd; redir_pct = rr; lat_extra = lx;
    endtask

    task automatic do_reset();
        #2;
        im_rvalid = 1'b0; im_gnt = 1'b0; redirect = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_im_req", 32'(im_req), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_pc_inc", 32'(out_pc_inc), 32'd0);
        mem_addr.delete(); mem_due.delete(); gaddr.delete(); deliv.delete();
        expq_pc.delete(); expq_in.delete(); pend_addr.delete(); pend_stale.delete();
        mpc = 16'h0000; ndrop = 0; coinc = 0; saw_fffc = 0; inc_fffc = '1;
        resp_cnt = 0; grants = 0; first_g = -1; first_v = -1;
        resp_lim = 1 << 30; redir_once = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("reset_pc", 32'(im_addr), 32'h0000);
        chk("reset_pc_param", 32'(w_im_addr), 32'hFFF8);
        @(posedge clk);
        #1;
    endtask

    task automatic compare();
        bit exp_v, exp_req;
        exp_v = expq_pc.size() != 0;
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
            chk("out_pc", 32'(out_pc), 32'(expq_pc[0]));
            chk("out_instr", 32'(out_instr), 32'(expq_in[0]));
            chk("out_pc_inc", 32'(out_pc_inc), 32'(16'(expq_pc[0] + 16'd4)));
        end
        exp_req = !redirect && (pend_addr.size() + expq_pc.size() < 4);
        chk("im_req", 32'(im_req), 32'(exp_req));
        if (exp_req)
            chk("im_addr", 32'(im_addr), 32'(mpc));
        if (out_valid && out_pc == 16'hFFFC) begin
            saw_fffc = 1;
            inc_fffc = out_pc_inc;
        end
    endtask

    task automatic model_update();
        bit exp_req, popped, stale;
        logic [15:0] a;
        exp_req = !redirect && (pend_addr.size() + expq_pc.size() < 4);
        popped = 0;
        if (expq_pc.size() != 0 && out_ready) begin
            deliv.push_back(expq_pc.pop_front());
            void'(expq_in.pop_front());
            popped = 1;
        end
        if (im_rvalid) begin
            a = pend_addr.pop_front();
            stale = pend_stale.pop_front();
            if (stale) ndrop++;
            if (!redirect && !stale) begin
                expq_pc.push_back(a);
                expq_in.push_back(imem(a));
            end
        end
        if (redirect && im_rvalid && popped) coinc = 1;
        if (redirect) begin
            expq_pc.delete(); expq_in.delete();
            foreach (pend_stale[i]) pend_stale[i] = 1;
            mpc = redirect_pc;
        end else if (exp_req && im_gnt) begin
            pend_addr.push_back(mpc);
            pend_stale.push_back(0);
            mpc = mpc + 16'd4;
        end
    endtask

    task automatic env_update();
        if (im_rvalid) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
            resp_cnt++;
        end
        if (im_req && im_gnt) begin
            mem_addr.push_back(im_addr);
            mem_due.push_back(cyc + 1 + $urandom_range(lat_extra));
            gaddr.push_back(im_addr);
            grants++;
            if (first_g < 0) first_g = cyc;
        end
        if (out_valid && first_v < 0) first_v = cyc;
    endtask

    task automatic step();
        cyc++;
        redirect = redir_once || ($urandom_range(99) < redir_pct);
        redirect_pc = redir_once ? redir_addr : (16'($urandom) & 16'hFFFC);
        redir_once = 0;
        im_gnt = $urandom_range(99) < gnt_pct;
        out_ready = $urandom_range(99) < ready_pct;
        im_rvalid = 1'b0;
        im_rdata = 16'($urandom);
        if (mem_addr.size() != 0 && mem_due[0] <= cyc && resp_cnt < resp_lim
            && $urandom_range(99) < rv_pct) begin
            im_rvalid = 1'b1;
            im_rdata = imem(mem_addr[0]);
        end
        @(negedge clk);
        compare();
        model_update();
        env_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        knobs(0, 0, 0, 0, 0);
        // Stream at full rate
        do_reset();
        knobs(100, 100, 100, 0, 0);
        repeat (10) step();
        chk("stream_pc0", 32'(deliv[0]), 32'h0000);
        chk("stream_pc1", 32'(deliv[1]), 32'h0004);
        chk("stream_pc2", 32'(deliv[2]), 32'h0008);
        chk("first_valid_delay", 32'(first_v - first_g), 32'd2);

        // Backpressure fills exactly DEPTH credits
        do_reset();
        knobs(100, 100, 0, 0, 0);
        repeat (10) step();
        chk("bp_grants", 32'(grants), 32'd4);
        chk("bp_im_req_low", 32'(im_req), 32'd0);
        ready_pct = 100;
        repeat (10) step();
        chk("bp_drain0", 32'(deliv[0]), 32'h0000);
        chk("bp_drain3", 32'(deliv[3]), 32'h000C);
        chk("bp_resume", 32'(gaddr[4]), 32'h0010);

        // Redirect with 2 buffered and 2 in flight
        do_reset();
        knobs(100, 100, 0, 0, 0);
        resp_lim = 2;
        repeat (8) step();
        redir_once = 1; redir_addr = 16'h0100;
        step();
        chk("redir_valid_low", 32'(out_valid), 32'd0);
        resp_lim = 1 << 30; ready_pct = 100;
        repeat (12) step();
        chk("redir_dropped", 32'(ndrop), 32'd2);
        chk("redir_pc0", 32'(deliv[0]), 32'h0100);
        chk("redir_pc1", 32'(deliv[1]), 32'h0104);

        // Redirect coincident with pop and response
        do_reset();
        knobs(100, 100, 100, 0, 0);
        repeat (6) step();
        redir_once = 1; redir_addr = 16'h0200;
        step();
        n0 = deliv.size();
        repeat (8) step();
        chk("coinc_hit", 32'(coinc), 32'd1);
        chk("coinc_next", 32'(deliv[n0]), 32'h0200);
        chk("coinc_nodup", 32'(deliv[n0-1]), 32'(16'(deliv[n0-2] + 16'd4)));

        // PC wrap
        do_reset();
        knobs(100, 100, 100, 0, 0);
        redir_once = 1; redir_addr = 16'hFFF8;
        repeat (10) step();
        chk("wrap_pc0", 32'(deliv[0]), 32'hFFF8);
        chk("wrap_pc1", 32'(deliv[1]), 32'hFFFC);
        chk("wrap_pc2", 32'(deliv[2]), 32'h0000);
        chk("wrap_seen", 32'(saw_fffc), 32'd1);
        chk("wrap_inc", 32'(inc_fffc), 32'h0000);

        // Randomized traffic
        do_reset();
        knobs(60, 70, 60, 5, 3);
        repeat (2500) step();
        knobs(80, 80, 80, 20, 2);
        repeat (800) step();

        // Async reset mid-stream, then restart
        knobs(100, 100, 100, 0, 1);
        repeat (5) step();
        do_reset();
        knobs(100, 100, 100, 0, 0);
        repeat (6) step();
        chk("restart_pc0", 32'(deliv[0]), 32'h0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
